// File: rtl/acc_drain_pkg.sv
// Shared types and constants for the FP16 accumulator sequencer/drain stage.
package acc_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam int unsigned FP16_SIGN_BIT = 15;

  // Any value with the sign bit set (-0, negatives, -NaN) becomes +0.
  function automatic logic [15:0] fp16_relu(input logic [15:0] v);
    return v[FP16_SIGN_BIT] ? FP16_ZERO : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with raw head read; push on a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_drain_seq_fp16.sv
// Clear/accumulate/drain sequencer for a column FP16 accumulator, feeding an output FIFO.
// Optional ACC_DRAIN_RELU_EN: ReLU applied to each captured sum before the FIFO push.
module acc_drain_seq_fp16
  import acc_drain_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic [CNT_W-1:0] n_vec,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc_in,
  output logic             acc_enable,
  output logic             acc_clear,
  input  logic [WIDTH-1:0] acc_sum,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            k_len_q, n_vec_q, term_cnt_q, vec_cnt_q;
  logic                        handshake, push, pop, can_push, last_term, last_vec;
  logic [WIDTH-1:0]            push_data, fifo_head, last_q;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Compare one bit wider so +1 never wraps at the top of the counter range.
  assign last_term = ({1'b0, term_cnt_q} + {1'b0, CNT_ONE}) == {1'b0, k_len_q};
  assign last_vec  = ({1'b0, vec_cnt_q}  + {1'b0, CNT_ONE}) == {1'b0, n_vec_q};
  assign handshake = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign can_push  = ~fifo_full | pop;

`ifdef ACC_DRAIN_RELU_EN
  assign push_data = fp16_relu(acc_sum);
`else
  assign push_data = acc_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_len_q    <= '0;
      n_vec_q    <= '0;
      term_cnt_q <= '0;
      vec_cnt_q  <= '0;
      last_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        k_len_q   <= k_len;
        n_vec_q   <= (n_vec == '0) ? CNT_ONE : n_vec;
        vec_cnt_q <= '0;
      end
      if (state_q == CLEAR) term_cnt_q <= '0;
      if (handshake)        term_cnt_q <= term_cnt_q + CNT_ONE;
      if (push)             vec_cnt_q  <= vec_cnt_q + CNT_ONE;
      if (pop)              last_q     <= fifo_head;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (k_len_q == '0) ? DRAIN : ACCUM;
      ACCUM:   if (handshake && last_term) state_d = DRAIN;
      DRAIN:   if (push) state_d = last_vec ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Everything is forced quiet while reset is held, whatever state was current.
  always_comb begin
    in_ready   = 1'b0;
    acc_enable = 1'b0;
    acc_in     = FP16_ZERO;
    acc_clear  = reset;
    push       = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      case (state_q)
        CLEAR: acc_clear = 1'b1;
        ACCUM: begin
          in_ready   = (term_cnt_q < k_len_q);
          acc_enable = in_valid & (term_cnt_q < k_len_q);
          if (in_valid && (term_cnt_q < k_len_q)) acc_in = in_data;
        end
        DRAIN: begin
          acc_enable = 1'b1;
          push       = can_push;
        end
        default: ;
      endcase
    end
  end

  assign done      = push & last_vec;
  assign out_valid = ~reset & (fifo_count != '0);
  assign out_data  = reset ? '0 : (fifo_empty ? last_q : fifo_head);

  sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_acc_drain_seq_fp16.sv
// Scoreboard bench: integer-valued FP16 operands, environment accumulator model, queue-based result checking.
module tb_acc_drain_seq_fp16;

  localparam int W  = 16;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [CW-1:0] k_len, n_vec;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic [W-1:0]  acc_in;
  logic          acc_enable, acc_clear;
  logic [W-1:0]  acc_sum;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          busy, done;

  always #5 clk = ~clk;

  acc_drain_seq_fp16 #(.WIDTH(16), .CNT_W(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .n_vec(n_vec),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_in(acc_in), .acc_enable(acc_enable), .acc_clear(acc_clear), .acc_sum(acc_sum),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  int n_checks = 0, n_fail = 0;
  int src_q[$];
  logic [15:0] exp_q[$];
  int vmode = 0, sink_mode = 0;
  int acc_int = 0;
  int done_cnt = 0, clr_cnt = 0, hs_cnt = 0, ir_cnt = 0;
  logic tog = 1'b1;

  // Exact for integers with magnitude below 2048.
  function automatic logic [15:0] int_to_fp16(input int v);
    int mag;
    int e;
    logic [15:0] r;
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 16'h0000;
    e = 0;
    for (int i = 0; i < 11; i++) if ((mag >> i) != 0) e = i;
    r[15]    = (v < 0);
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'((mag << (10 - e)) & 32'h3FF);
    return r;
  endfunction

  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int mag;
    e = int'(h[14:10]);
    if (e == 0) return 0;
    mag = (1024 + int'(h[9:0])) >> (25 - e);
    return h[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] expect_word(input int s);
    logic [15:0] w;
    w = int_to_fp16(s);
`ifdef ACC_DRAIN_RELU_EN
    if (w[15]) w = 16'h0000;
`endif
    return w;
  endfunction

  function automatic int op_of(input int mode, input int t);
    case (mode)
      1:       return 1;
      2:       return t + 1;
      3:       return (t == 0) ? 1 : -2;
      default: return $urandom_range(0, 16) - 8;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // External FP16 accumulator, modelled with integer arithmetic.
  always @(posedge clk) begin
    if (acc_clear)       acc_int <= 0;
    else if (acc_enable) acc_int <= acc_int + fp16_to_int(acc_in);
  end
  assign acc_sum = int_to_fp16(acc_int);

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (src_q.size() > 0) begin
        in_data = int_to_fp16(src_q[0]);
        case (vmode)
          1:       in_valid = tog;
          2:       in_valid = 1'($urandom_range(0, 1));
          default: in_valid = 1'b1;
        endcase
        tog = ~tog;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
        tog      = 1'b1;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pop on every output handshake plus event counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (done)      done_cnt++;
      if (acc_clear) clr_cnt++;
      if (in_ready)  ir_cnt++;
      if (in_valid && in_ready) begin
        hs_cnt++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (!acc_enable) chk("acc_in_when_disabled", 32'(acc_in), 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h required no output", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic pulse_start(input int k, input int n);
    @(posedge clk); #1;
    k_len = CW'(k);
    n_vec = CW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("clear_after_start", 32'(acc_clear), 32'h1);
    chk("busy_after_start", 32'(busy), 32'h1);
  endtask

  task automatic wait_idle(input string nm);
    int cyc;
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, 32'(cyc < 3000), 32'h1);
  endtask

  task automatic run_cmd(input int k, input int n, input int opmode);
    int nv, s, dc0, cc0, ir0;
    nv = (n == 0) ? 1 : n;
    for (int v = 0; v < nv; v++) begin
      s = 0;
      for (int t = 0; t < k; t++) begin
        int op;
        op = op_of(opmode, t);
        src_q.push_back(op);
        s += op;
      end
      exp_q.push_back(expect_word(s));
    end
    dc0 = done_cnt;
    cc0 = clr_cnt;
    ir0 = ir_cnt;
    pulse_start(k, n);
    wait_idle("cmd_timeout");
    chk("done_pulses", 32'(done_cnt - dc0), 32'h1);
    chk("clear_pulses", 32'(clr_cnt - cc0), 32'(nv));
    if (k == 0) chk("k0_no_in_ready", 32'(ir_cnt - ir0), 32'h0);
  endtask

  task automatic wait_scoreboard_empty();
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, hs0, cyc;
    reset = 1'b1;
    start = 1'b0;
    k_len = '0;
    n_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_acc_clear", 32'(acc_clear), 32'h1);
    chk("rst_acc_enable", 32'(acc_enable), 32'h0);
    chk("rst_acc_in", 32'(acc_in), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1 + 2 + 3 = 6.0
    run_cmd(3, 1, 2);
    wait_scoreboard_empty();
    chk("out_data_holds_when_empty", 32'(out_data), 32'h4600);

    vmode = 1;
    run_cmd(4, 2, 1);
    vmode = 0;
    wait_scoreboard_empty();

    // Backpressure: four results fill the FIFO, fifth sum waits in DRAIN.
    sink_mode = 1;
    for (int t = 0; t < 6; t++) begin
      src_q.push_back(t + 1);
      exp_q.push_back(expect_word(t + 1));
    end
    dc0 = done_cnt;
    hs0 = hs_cnt;
    pulse_start(1, 6);
    repeat (40) @(negedge clk);
    chk("bp_busy", 32'(busy), 32'h1);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    chk("bp_acc_enable", 32'(acc_enable), 32'h1);
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_no_done", 32'(done_cnt - dc0), 32'h0);
    chk("bp_handshakes", 32'(hs_cnt - hs0), 32'h5);
    sink_mode = 0;
    wait_idle("bp_timeout");
    chk("bp_done", 32'(done_cnt - dc0), 32'h1);
    chk("bp_handshakes_total", 32'(hs_cnt - hs0), 32'h6);
    wait_scoreboard_empty();

    run_cmd(0, 2, 0);
    wait_scoreboard_empty();

    // Abort mid-ACCUM after two of five terms; nothing may be emitted.
    for (int t = 0; t < 5; t++) src_q.push_back(1);
    hs0 = hs_cnt;
    pulse_start(5, 1);
    cyc = 0;
    while ((hs_cnt - hs0) < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_two_terms", 32'(hs_cnt - hs0), 32'h2);
    @(posedge clk); #1;
    reset = 1'b1;
    src_q.delete();
    @(negedge clk);
    chk("abort_rst_busy", 32'(busy), 32'h0);
    chk("abort_rst_acc_clear", 32'(acc_clear), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'h0);
    run_cmd(3, 1, 0);
    wait_scoreboard_empty();

    // 1 + (-2): 0xBC00, or 0x0000 with ReLU.
    run_cmd(2, 1, 3);
    wait_scoreboard_empty();

    vmode = 2;
    sink_mode = 2;
    repeat (25) run_cmd(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0);
    sink_mode = 0;
    wait_scoreboard_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
